// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO with registered occupancy count; read data is
// presented combinationally from the head entry.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame serializer with per-frame latched
// baud divisor, optional parity and 1 or 2 stop bits.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic                        tx_enable,
  input  logic                        s_valid,
  input  logic [DATA_BITS-1:0]        s_data,
  output logic                        s_ready,
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_INV   = (PARITY_MODE == PARITY_ODD);
  localparam logic       HAS_PAR   = (PARITY_MODE != PARITY_NONE);

  tx_state_t            state, state_n;
  logic [DIV_WIDTH-1:0] baud_cnt, baud_cnt_n;
  logic [DIV_WIDTH-1:0] div_lat, div_lat_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_n, busy_n;
  logic                 load_frame;
  logic                 bit_done;
  logic                 can_start;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_ready   = !fifo_full;
  assign bit_done  = (baud_cnt == div_lat);
  assign can_start = tx_enable && !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_lat  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      div_lat  <= div_lat_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_bit  <= par_bit_n;
      tx_out   <= tx_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    div_lat_n  = div_lat;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_bit_n  = par_bit;
    tx_n       = tx_out;
    busy_n     = busy;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;

    if (state != IDLE) baud_cnt_n = bit_done ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE: if (can_start) load_frame = 1'b1;
      START: if (bit_done) begin
        state_n   = DATA;
        tx_n      = shift[0];
        shift_n   = shift >> 1;
        bit_cnt_n = '0;
      end
      DATA: if (bit_done) begin
        if (bit_cnt == LAST_DATA) begin
          bit_cnt_n = '0;
          if (HAS_PAR) begin
            state_n = PARITY;
            tx_n    = par_bit;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          tx_n      = shift[0];
          shift_n   = shift >> 1;
        end
      end
      PARITY: if (bit_done) begin
        state_n   = STOP;
        tx_n      = 1'b1;
        bit_cnt_n = '0;
      end
      STOP: if (bit_done) begin
        if (bit_cnt == LAST_STOP) begin
          if (can_start) begin
            load_frame = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Frame start is shared by IDLE and the end of the last stop bit so that
    // queued words follow with no idle gap.
    if (load_frame) begin
      fifo_pop   = 1'b1;
      state_n    = START;
      tx_n       = 1'b0;
      busy_n     = 1'b1;
      div_lat_n  = baud_div;
      baud_cnt_n = '0;
      bit_cnt_n  = '0;
      shift_n    = fifo_data;
      par_bit_n  = (^fifo_data) ^ ODD_INV;
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY_MODE, default 0, where 0 is none, 1 is even and 2 is odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries (power of 2, at least 2).
REQ-005 SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor.
REQ-006 SHALL have port clk, input, 1 bit: clock, all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port baud_div, input, DIV_WIDTH bits: clocks per bit minus 1.
REQ-009 SHALL have port tx_enable, input, 1 bit: permits new frames to start.
REQ-010 SHALL have port s_valid, input, 1 bit: write request.
REQ-011 SHALL have port s_data, input, DATA_BITS bits: word to send.
REQ-012 SHALL have port s_ready, output, 1 bit: FIFO can accept a word.
REQ-013 SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: words held.

Function
REQ-016 SHALL accept a word on a clock edge where s_valid and s_ready are both high; s_ready SHALL equal not-full (combinational); a write while full SHALL be impossible.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; IDLE SHALL go to START when the FIFO is non-empty and tx_enable is high, popping one word on that edge.
REQ-018 tx_out SHALL go low on the pop edge, so a word accepted into an empty FIFO while IDLE starts its start bit exactly 1 clock after the accept edge.
REQ-019 baud_div SHALL be latched at pop; every bit of that frame SHALL last exactly latched_div+1 clocks; changes mid-frame SHALL be ignored; baud_div=0 SHALL give 1 clock per bit.
REQ-020 The bit-timing counter SHALL restart at each frame start (not free-running).
REQ-021 Data SHALL be sent LSB first, DATA_BITS bits, from START to DATA to PARITY (skipped when PARITY_MODE=0) to STOP.
REQ-022 The parity bit SHALL be the XOR of the data when even and XNOR when odd, computed from the popped word.
REQ-023 STOP SHALL hold tx_out high for STOP_BITS bit times.
REQ-024 At the end of the last stop bit, if the FIFO is non-empty and tx_enable is high, the FSM SHALL pop and enter START on the same edge (no idle gap); otherwise it SHALL enter IDLE.
REQ-025 tx_enable deasserted mid-frame SHALL NOT abort the frame; it SHALL only block the next start.
REQ-026 A push and a pop on the same edge SHALL leave fifo_count unchanged; a push to an empty FIFO SHALL NOT bypass the FIFO.
REQ-027 busy SHALL be registered, high from the pop edge until the edge returning to IDLE.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL distinguish full from empty.

Reset
REQ-029 On reset assertion, asynchronously, tx_out SHALL go to 1, busy to 0, fifo_count to 0, FSM to IDLE and bit counters to 0; s_ready SHALL be 1.
REQ-030 Reset mid-frame SHALL abort the frame immediately and discard all FIFO contents.

Structure
REQ-031 The FSM state encoding and the PARITY_MODE constants (NONE=0, EVEN=1, ODD=2) SHALL live in shared package uart_pkg.
REQ-032 The FIFO SHALL be sub-module uart_tx_fifo (synchronous, single clock, registered count).

Verification
REQ-033 Default params, baud_div=3, push 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, start 1 clock after accept, busy high 40 clocks.
REQ-034 PARITY_MODE=1, push 0x07 -> parity bit 1; PARITY_MODE=2, same word -> parity bit 0; frame 11 bit times.
REQ-035 FIFO_DEPTH=4, tx_enable=0, push 5 words -> s_ready low after 4th, fifo_count=4; raise tx_enable -> 4 back-to-back frames with no idle high between stop and start, count stepping 3,2,1,0.
REQ-036 STOP_BITS=2, baud_div=1 -> stop high 4 clocks; next queued frame starts on clock 5.
REQ-037 Assert reset during data bit 3 -> tx_out=1 and fifo_count=0 before the next clock edge, busy=0; after release, push 0x3C -> correct frame.
REQ-038 baud_div changed 3->7 mid-frame -> current frame stays 4 clocks/bit, next frame 8 clocks/bit.
